// File: rtl/ulpi_pkg.sv
// Shared ULPI definitions: controller states, TX CMD prefixes, common PHY
// register addresses and RX CMD field positions.
package ulpi_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_PEND,
    ST_WDATA,
    ST_WSTP,
    ST_RTURN,
    ST_RDATA,
    ST_RWAIT,
    ST_TSTP
  } state_t;

  localparam logic [1:0] TXCMD_REGWR = 2'b10;
  localparam logic [1:0] TXCMD_REGRD = 2'b11;

  localparam logic [5:0] REG_VENDOR_ID = 6'h00;
  localparam logic [5:0] REG_FUNC_CTRL = 6'h04;
  localparam logic [5:0] REG_IFC_CTRL  = 6'h07;
  localparam logic [5:0] REG_OTG_CTRL  = 6'h0A;

  // RX CMD byte layout: linestate [1:0], vbus [3:2], rxevent [5:4]
  localparam int RXCMD_LINESTATE_LSB = 0;
  localparam int RXCMD_VBUS_LSB      = 2;
  localparam int RXCMD_RXEVENT_LSB   = 4;
  localparam int RXCMD_FIELD_W       = 2;

  function automatic logic [7:0] txcmd_byte(input logic wr, input logic [5:0] addr);
    return {(wr ? TXCMD_REGWR : TXCMD_REGRD), addr};
  endfunction

  function automatic logic [1:0] rxcmd_linestate(input logic [7:0] b);
    return b[RXCMD_LINESTATE_LSB +: RXCMD_FIELD_W];
  endfunction

  function automatic logic [1:0] rxcmd_vbus(input logic [7:0] b);
    return b[RXCMD_VBUS_LSB +: RXCMD_FIELD_W];
  endfunction

  function automatic logic [1:0] rxcmd_rxevent(input logic [7:0] b);
    return b[RXCMD_RXEVENT_LSB +: RXCMD_FIELD_W];
  endfunction

endpackage

// File: rtl/ulpi_reg_ctrl.sv
// ULPI register-access sequencer sharing the bus with the link transmitter;
// also captures RX CMD bytes. NXT timeout is built only with ULPI_REG_TIMEOUT_EN.
module ulpi_reg_ctrl
  import ulpi_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 6
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_reg_valid,
  output logic              o_reg_ready,
  input  logic              i_reg_write,
  input  logic [ADDR_W-1:0] i_reg_addr,
  input  logic [7:0]        i_reg_wdata,
  output logic              o_rsp_valid,
  output logic [7:0]        o_rsp_rdata,
  output logic              o_rsp_err,
  input  logic              i_link_txActive,
  input  logic [7:0]        i_link_data,
  input  logic              i_link_stp,
  output logic              o_link_hold,
  input  logic              i_ulpi_dir,
  input  logic              i_ulpi_nxt,
  input  logic [7:0]        i_ulpi_data_in,
  output logic [7:0]        o_ulpi_data_out,
  output logic              o_ulpi_stp,
  output logic [7:0]        o_rxcmd,
  output logic              o_rxcmd_valid
);

  state_t            state;
  logic              run;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_wdata;
  logic [7:0]        rdata_cap;
  logic              rwait_err;
  logic              dir_q;
  logic              accept;

`ifdef ULPI_REG_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  // run keeps every output at 0 while reset is held, including the pass-through
  assign o_reg_ready = run && (state == ST_IDLE) && !i_ulpi_dir && !i_link_txActive;
  assign accept      = i_reg_valid && o_reg_ready;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= ST_IDLE;
      run         <= 1'b0;
      req_write   <= 1'b0;
      req_addr    <= '0;
      req_wdata   <= '0;
      rdata_cap   <= '0;
      rwait_err   <= 1'b0;
      o_link_hold <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= '0;
      o_rsp_err   <= 1'b0;
`ifdef ULPI_REG_TIMEOUT_EN
      cnt         <= '0;
`endif
    end else begin
      run         <= 1'b1;
      o_rsp_valid <= 1'b0;
      o_rsp_err   <= 1'b0;
`ifdef ULPI_REG_TIMEOUT_EN
      cnt <= ((state == ST_CMD) || (state == ST_WDATA)) ? cnt + 8'd1 : 8'd0;
`endif
      case (state)
        ST_IDLE: begin
          if (accept) begin
            req_write   <= i_reg_write;
            req_addr    <= i_reg_addr;
            req_wdata   <= i_reg_wdata;
            o_link_hold <= 1'b1;
            state       <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (i_ulpi_nxt) begin
            state <= req_write ? ST_WDATA : ST_RTURN;
`ifdef ULPI_REG_TIMEOUT_EN
            cnt   <= '0;
`endif
          end else if (i_ulpi_dir) begin
            state <= ST_PEND;
          end
`ifdef ULPI_REG_TIMEOUT_EN
          else if (cnt == TO_LAST) begin
            state <= ST_TSTP;
          end
`endif
        end
        // PHY took the bus before accepting the TX CMD; reissue once it is free
        ST_PEND: begin
          if (!i_ulpi_dir && !i_link_txActive) state <= ST_CMD;
        end
        ST_WDATA: begin
          if (i_ulpi_nxt) begin
            state <= ST_WSTP;
          end else if (i_ulpi_dir) begin
            state       <= ST_IDLE;
            o_link_hold <= 1'b0;
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= 1'b1;
          end
`ifdef ULPI_REG_TIMEOUT_EN
          else if (cnt == TO_LAST) begin
            state <= ST_TSTP;
          end
`endif
        end
        ST_WSTP: begin
          state       <= ST_IDLE;
          o_link_hold <= 1'b0;
          o_rsp_valid <= 1'b1;
        end
        ST_RTURN: begin
          if (i_ulpi_dir) begin
            state <= ST_RDATA;
          end else begin
            state       <= ST_IDLE;
            o_link_hold <= 1'b0;
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= 1'b1;
          end
        end
        ST_RDATA: begin
          rdata_cap <= i_ulpi_data_in;
          rwait_err <= 1'b0;
          state     <= ST_RWAIT;
        end
        // NXT with DIR here means an RX packet began before the PHY released the bus
        ST_RWAIT: begin
          if (!i_ulpi_dir) begin
            state       <= ST_IDLE;
            o_link_hold <= 1'b0;
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= rwait_err;
            o_rsp_rdata <= rdata_cap;
          end else if (i_ulpi_nxt) begin
            rwait_err <= 1'b1;
          end
        end
        ST_TSTP: begin
          state       <= ST_IDLE;
          o_link_hold <= 1'b0;
          o_rsp_valid <= 1'b1;
          o_rsp_err   <= 1'b1;
        end
        default: begin
          state       <= ST_IDLE;
          o_link_hold <= 1'b0;
        end
      endcase
    end
  end

  // RX CMD: DIR held high with NXT low, past the turnaround cycle
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      dir_q         <= 1'b0;
      o_rxcmd       <= '0;
      o_rxcmd_valid <= 1'b0;
    end else begin
      dir_q         <= i_ulpi_dir;
      o_rxcmd_valid <= 1'b0;
      if (i_ulpi_dir && !i_ulpi_nxt && dir_q && (state != ST_RDATA)) begin
        o_rxcmd       <= i_ulpi_data_in;
        o_rxcmd_valid <= 1'b1;
      end
    end
  end

  always_comb begin
    o_ulpi_data_out = '0;
    o_ulpi_stp      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (run && !i_ulpi_dir) begin
          o_ulpi_data_out = i_link_data;
          o_ulpi_stp      = i_link_stp;
        end
      end
      ST_CMD:   o_ulpi_data_out = txcmd_byte(req_write, req_addr);
      ST_WDATA: o_ulpi_data_out = req_wdata;
      ST_WSTP:  o_ulpi_stp      = 1'b1;
      ST_TSTP:  o_ulpi_stp      = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ulpi_reg_ctrl.sv
// Directed bench for ulpi_reg_ctrl: stimulus queues expected responses,
// a negedge monitor pops and compares them when rsp_valid pulses.
module tb_ulpi_reg_ctrl;

`ifdef ULPI_REG_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic       clk = 1'b0;
  logic       rstn;
  logic       reg_valid, reg_ready, reg_write;
  logic [5:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic       link_tx, link_stp, link_hold;
  logic [7:0] link_data;
  logic       dir, nxt, stp;
  logic [7:0] data_in, data_out, rxcmd;
  logic       rxcmd_valid;

  ulpi_reg_ctrl #(.TIMEOUT_CYCLES(TO), .ADDR_W(6)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_reg_valid(reg_valid), .o_reg_ready(reg_ready), .i_reg_write(reg_write),
    .i_reg_addr(reg_addr), .i_reg_wdata(reg_wdata),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
    .i_link_txActive(link_tx), .i_link_data(link_data), .i_link_stp(link_stp),
    .o_link_hold(link_hold),
    .i_ulpi_dir(dir), .i_ulpi_nxt(nxt), .i_ulpi_data_in(data_in),
    .o_ulpi_data_out(data_out), .o_ulpi_stp(stp),
    .o_rxcmd(rxcmd), .o_rxcmd_valid(rxcmd_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  typedef struct {
    logic [7:0] rdata;
    bit         chk_rdata;
    bit         err;
    int         cyc;
    bit         chk_cyc;
  } exp_t;
  exp_t sb[$];

  task automatic push(input logic [7:0] rd, input bit chk_rd, input bit err,
                      input int c, input bit chk_c);
    exp_t e;
    e.rdata = rd; e.chk_rdata = chk_rd; e.err = err; e.cyc = c; e.chk_cyc = chk_c;
    sb.push_back(e);
  endtask

  // Monitor: every response pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        if (e.chk_rdata) chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
        if (e.chk_cyc)   chk("rsp_latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request in IDLE; returns the cycle number in which it is accepted
  task automatic start_req(input logic w, input logic [5:0] a, input logic [7:0] d,
                           output int acc);
    reg_valid = 1'b1; reg_write = w; reg_addr = a; reg_wdata = d;
    #1;
    chk("reg_ready", 32'(reg_ready), 32'd1);
    acc = cyc;
    step();
    reg_valid = 1'b0;
  endtask

  task automatic do_write(input logic [5:0] a, input logic [7:0] d, input string tag);
    int acc;
    start_req(1'b1, a, d, acc);
    push(8'h00, 1'b0, 1'b0, acc + 4, 1'b1);
    nxt = 1'b1;
    #1;
    chk({tag, "_cmd"}, 32'(data_out), 32'({2'b10, a}));
    chk({tag, "_hold"}, 32'(link_hold), 32'd1);
    step();
    #1;
    chk({tag, "_wdata"}, 32'(data_out), 32'(d));
    step();
    nxt = 1'b0;
    #1;
    chk({tag, "_stp"}, 32'(stp), 32'd1);
    chk({tag, "_stp_data"}, 32'(data_out), 32'd0);
    step();
    #1;
    chk({tag, "_hold_rel"}, 32'(link_hold), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int stp_n;
    int stp_cyc;

    rstn = 1'b0; reg_valid = 1'b0; reg_write = 1'b0; reg_addr = '0; reg_wdata = '0;
    link_tx = 1'b0; link_data = 8'hA5; link_stp = 1'b1;
    dir = 1'b0; nxt = 1'b0; data_in = '0;
    #2;
    chk("rst_ready", 32'(reg_ready), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_stp", 32'(stp), 32'd0);
    chk("rst_hold", 32'(link_hold), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rxcmd", 32'({rxcmd_valid, rxcmd}), 32'd0);
    step(); step();
    rstn = 1'b1;
    step();
    #1;
    chk("idle_passthru_data", 32'(data_out), 32'hA5);
    chk("idle_passthru_stp", 32'(stp), 32'd1);
    link_data = 8'h00; link_stp = 1'b0;

    // Register write with NXT every cycle
    do_write(6'h04, 8'h45, "wr");

    // Register read: NXT, turnaround, data 0x24, DIR released
    start_req(1'b0, 6'h00, 8'h00, acc);
    push(8'h24, 1'b1, 1'b0, acc + 5, 1'b1);
    nxt = 1'b1;
    #1;
    chk("rd_cmd", 32'(data_out), 32'hC0);
    step();
    nxt = 1'b0; dir = 1'b1;
    #1;
    chk("rd_turn_data", 32'(data_out), 32'd0);
    step();
    data_in = 8'h24;
    step();
    dir = 1'b0; data_in = 8'h00;
    #1;
    chk("rd_no_rxcmd", 32'(rxcmd_valid), 32'd0);
    step();
    step();

    // PHY takes the bus during CMD with RX CMD 0x01; TX CMD is reissued
    start_req(1'b1, 6'h0A, 8'h5A, acc);
    push(8'h00, 1'b0, 1'b0, 0, 1'b0);
    dir = 1'b1;
    #1;
    chk("pend_cmd1", 32'(data_out), 32'h8A);
    step();
    data_in = 8'h01;
    #1;
    chk("pend_data", 32'(data_out), 32'd0);
    step();
    dir = 1'b0; data_in = 8'h00;
    #1;
    chk("pend_rxcmd_valid", 32'(rxcmd_valid), 32'd1);
    chk("pend_rxcmd", 32'(rxcmd), 32'h01);
    step();
    nxt = 1'b1;
    #1;
    chk("pend_cmd2", 32'(data_out), 32'h8A);
    step();
    #1;
    chk("pend_wdata", 32'(data_out), 32'h5A);
    step();
    nxt = 1'b0;
    #1;
    chk("pend_stp", 32'(stp), 32'd1);
    step();
    step();

    // Request and link transmit rise together: link wins
    reg_valid = 1'b1; reg_write = 1'b1; reg_addr = 6'h07; reg_wdata = 8'h11;
    link_tx = 1'b1; link_data = 8'h40;
    #1;
    chk("arb_ready0", 32'(reg_ready), 32'd0);
    chk("arb_pass0", 32'(data_out), 32'h40);
    step();
    link_data = 8'h41; link_stp = 1'b1;
    #1;
    chk("arb_ready1", 32'(reg_ready), 32'd0);
    chk("arb_pass1", 32'({stp, data_out}), 32'h141);
    step();
    link_tx = 1'b0; link_data = 8'h00; link_stp = 1'b0;
    reg_valid = 1'b0;
    do_write(6'h07, 8'h11, "arb");

    // DIR in IDLE blocks pass-through and yields RX CMD 0x1E
    dir = 1'b1; link_tx = 1'b1; link_data = 8'h55;
    #1;
    chk("dir_force_data", 32'(data_out), 32'd0);
    chk("dir_ready", 32'(reg_ready), 32'd0);
    step();
    data_in = 8'h1E;
    step();
    dir = 1'b0; data_in = 8'h00; link_tx = 1'b0; link_data = 8'h00;
    #1;
    chk("idle_rxcmd", 32'({rxcmd_valid, rxcmd}), 32'h11E);
    step();

    // DIR during WDATA aborts the write with an error response
    start_req(1'b1, 6'h04, 8'h99, acc);
    push(8'h00, 1'b0, 1'b1, acc + 3, 1'b1);
    nxt = 1'b1;
    step();
    nxt = 1'b0; dir = 1'b1;
    #1;
    chk("abort_wdata", 32'(data_out), 32'h99);
    step();
    step();
    dir = 1'b0;
    step();

    // NXT never arrives
    start_req(1'b1, 6'h04, 8'h01, acc);
    stp_n = 0; stp_cyc = 0;
`ifdef ULPI_REG_TIMEOUT_EN
    push(8'h00, 1'b0, 1'b1, acc + 10, 1'b1);
    for (int i = 0; i < 14; i++) begin
      if (stp) begin stp_n++; stp_cyc = cyc; end
      step();
    end
    chk("to_stp_count", 32'(stp_n), 32'd1);
    chk("to_stp_cycle", 32'(stp_cyc), 32'(acc + 9));
`else
    for (int i = 0; i < 1000; i++) begin
      if (stp) stp_n++;
      step();
    end
    chk("noto_stp", 32'(stp_n), 32'd0);
    chk("noto_cmd", 32'(data_out), 32'h84);
    rstn = 1'b0;
    #1;
    chk("noto_rst_data", 32'(data_out), 32'd0);
    step();
    rstn = 1'b1;
    step();
`endif

    // Asynchronous reset while in WDATA
    start_req(1'b1, 6'h04, 8'h77, acc);
    nxt = 1'b1;
    step();
    nxt = 1'b0;
    #1;
    chk("rstw_pre", 32'(data_out), 32'h77);
    #1;
    rstn = 1'b0;
    #1;
    chk("rstw_data", 32'(data_out), 32'd0);
    chk("rstw_stp", 32'(stp), 32'd0);
    chk("rstw_hold", 32'(link_hold), 32'd0);
    chk("rstw_rsp", 32'(rsp_valid), 32'd0);
    step(); step();
    rstn = 1'b1;
    step();
    do_write(6'h04, 8'h3C, "post");

    step(); step(); step();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ulpi_reg_ctrl.md
Name: ulpi_reg_ctrl

Overview:
- Sequences ULPI PHY register reads and writes on the PHY-generated 60MHz ULPI clock.
- Shares the single ULPI bus between the USB link's packet transmitter and a register-access requester, e.g. PHY bring-up config or a debug bridge.
- Sits between the link and the FMC daughterboard pin wrapper; also captures RX CMD bytes (linestate/vbus) for the rest of the design.

Parameters:
TIMEOUT_CYCLES, 255, cycles to wait for NXT after issuing a TX CMD before aborting (used only with the optional feature).
ADDR_W, 6, register address width; fixed by ULPI short-address format.

Ports:
i_clk  in  1  ULPI 60MHz clock from PHY
i_rstn  in  1  asynchronous active-low reset
i_reg_valid  in  1  register request valid
o_reg_ready  out  1  request accepted when valid&&ready
i_reg_write  in  1  1=write, 0=read
i_reg_addr  in  ADDR_W  register address
i_reg_wdata  in  8  write data
o_rsp_valid  out  1  one-cycle response pulse; no backpressure
o_rsp_rdata  out  8  read data, valid with rsp_valid
o_rsp_err  out  1  access aborted, valid with rsp_valid
i_link_txActive  in  1  link owns or wants the bus
i_link_data  in  8  link TX data
i_link_stp  in  1  link STP
o_link_hold  out  1  link must not start a transmit
i_ulpi_dir  in  1  PHY DIR
i_ulpi_nxt  in  1  PHY NXT
i_ulpi_data_in  in  8  PHY data
o_ulpi_data_out  out  8  data to PHY
o_ulpi_stp  out  1  STP to PHY
o_rxcmd  out  8  last RX CMD byte
o_rxcmd_valid  out  1  pulse when o_rxcmd updates

Behaviour:
- Reset (async, i_rstn=0): state IDLE; all outputs 0; latched request cleared.
- Reset mid-access drops STP and data to 0 immediately, with no STP cycle.
- o_reg_ready = (state==IDLE) && !i_ulpi_dir && !i_link_txActive.
  - Same-cycle i_reg_valid and i_link_txActive rise: link wins.
- On accept: latch write, addr, wdata; o_link_hold=1 from the next cycle until the return to IDLE.
- In IDLE, o_ulpi_data_out/o_ulpi_stp pass through i_link_data/i_link_stp; both are forced to 0 while i_ulpi_dir=1.
- States:
  - CMD: drive {2'b10 write | 2'b11 read, addr}.
    - nxt=1 → WDATA (write) or RTURN (read).
    - dir=1 with nxt=0 → PEND (PHY abort; retry, no response).
  - PEND: drive 0. When dir=0 and link idle → CMD.
  - WDATA: drive wdata.
    - nxt=1 → WSTP.
    - dir=1 → IDLE with rsp_valid=1, rsp_err=1.
  - WSTP: stp=1, data_out=0 for exactly one cycle → IDLE with rsp_valid=1, err=0.
  - RTURN: data_out=0 (turnaround).
    - dir=1 → RDATA.
    - dir=0 → IDLE with err=1.
  - RDATA: capture i_ulpi_data_in into rsp_rdata; → RWAIT.
  - RWAIT: when dir=0 → IDLE with rsp_valid=1, err=0.
    - If nxt=1 while dir=1 (RX packet started), set err=1 at completion.
- Latency, no stalls:
  - Write: accept → rsp_valid 4 cycles (CMD, WDATA, WSTP, rsp).
  - Read: accept → rsp_valid 5 cycles.
- RX CMD capture: any cycle with dir=1 && nxt=0 && dir was 1 on the previous cycle (not a turnaround), outside RDATA → o_rxcmd=data_in, o_rxcmd_valid=1 next cycle.
- Response outputs are registered. rsp_rdata holds its value until the next response; err is 0 except during an err pulse.

Optional Feature:
ULPI_REG_TIMEOUT_EN.
- Defined: an 8-bit counter runs in CMD and WDATA and is cleared on state entry.
  - Reaching TIMEOUT_CYCLES without nxt → stp=1 for one cycle, then IDLE with rsp_valid=1, err=1.
- Undefined: no counter; the controller waits for NXT indefinitely.

Decomposition:
- Package ulpi_pkg holds:
  - the state enum;
  - TXCMD prefix constants (REGWR 2'b10, REGRD 2'b11);
  - common PHY register addresses (VENDOR_ID 6'h00, FUNC_CTRL 6'h04, IFC_CTRL 6'h07, OTG_CTRL 6'h0A);
  - the RX CMD field positions (linestate [1:0], vbus [3:2], rxevent [5:4]).
- No sub-module; the single FSM plus counter is natural.

Test Plan:
- Write addr 6'h04, data 8'h45, nxt=1 every cycle → data_out 8'h84, then 8'h45, then stp=1/data 0; rsp_valid 4 cycles after accept, err=0.
- Read addr 6'h00; PHY asserts nxt, then dir, returns 8'h24, drops dir → rsp_rdata=8'h24, err=0, rsp_valid 5 cycles after accept.
- dir rises during CMD (RX CMD 8'h01 presented) → o_rxcmd=8'h01 pulse; TX CMD reissued after dir falls; single response err=0.
- i_reg_valid and i_link_txActive rise together → ready=0 and link data passes through; request is accepted the first cycle link goes idle; o_link_hold=1 until rsp.
- Optional feature defined, TIMEOUT_CYCLES=8, nxt tied 0 → stp pulse after 8 cycles, rsp_valid with err=1. Undefined: no response after 1000 cycles.
- i_rstn low in WDATA → stp, data_out, rsp_valid and o_link_hold go to 0 asynchronously; after release, a new write completes normally.
